offset_cmd_loader: RTL and testbench

// - Sits between the UART receive/transmit streams and the bank of per-channel

---
 rtl/offset_cmd_loader.sv | 215 +++++++++++++++++++++
 tb/tb_offset_cmd_loader.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offset_cmd_loader.sv
// ---------------------------------------------------------------------------
// offset_cmd_loader
//
// Purpose:
//   Parses framed serial commands from a UART receive stream and writes
//   per-channel phase offsets into a register bank that feeds a set of clock
//   generators. Every committed write is followed by a one-cycle active-low
//   reload pulse. Every complete frame is answered with an ACK or NAK byte on
//   the UART transmit stream.
//
//   Frame: SYNC, CH, D2, D1, D0, CK  with CK = CH ^ D2 ^ D1 ^ D0 and
//   offset = {D2, D1, D0} resized to OFFSET_W bits (truncated or zero-extended).
//
// Optional feature (compile-time macro):
//   OFFSET_BROADCAST_EN - when defined, CH = 8'hFF with a good checksum writes
//                         the offset to every channel. When undefined, 8'hFF
//                         is just an out-of-range channel and gets a NAK.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   rx_data  in   [7:0] byte from UART receiver
//   rx_valid in   rx_data valid
//   rx_ready out  loader accepts the byte
//   tx_data  out  [7:0] reply byte (ACK_BYTE / NAK_BYTE)
//   tx_valid out  reply valid
//   tx_ready in   transmitter accepts the reply
//   offsets  out  [OUTPUTS*OFFSET_W-1:0], channel i at offsets[OFFSET_W*i +: OFFSET_W]
//   reload   out  generator reload, active-low single-cycle pulse
//
// Handshakes: a byte moves on rx when rx_valid & rx_ready are both high at a
// rising clk edge; the reply moves on tx when tx_valid & tx_ready are both
// high at a rising clk edge. Neither valid depends on the matching ready.
// ---------------------------------------------------------------------------
module offset_cmd_loader #(
    parameter int         OUTPUTS        = 16,
    parameter int         OFFSET_W       = 24,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 520800
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [OUTPUTS*OFFSET_W-1:0] offsets,
    output logic                        reload
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CH   = 3'd1,
        S_D2   = 3'd2,
        S_D1   = 3'd3,
        S_D0   = 3'd4,
        S_CK   = 3'd5,
        S_RESP = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]          ch_q;
    logic [7:0]          d2_q;
    logic [7:0]          d1_q;
    logic [7:0]          d0_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OFFSET_W-1:0] off_q [OUTPUTS];
    logic [OFFSET_W-1:0] new_off;
    logic [7:0]          tx_data_q;
    logic                rx_ready_q;
    logic                reload_q;

    logic rx_fire;
    logic tx_fire;
    logic in_frame;
    logic ck_fire;
    logic ck_ok;
    logic ch_ok;
    logic ch_bcast;
    logic commit_one;
    logic commit_all;
    logic timeout_hit;

    assign rx_fire = rx_valid & rx_ready_q;
    assign tx_fire = tx_valid & tx_ready;
    assign new_off = OFFSET_W'({d2_q, d1_q, d0_q});

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (rx_fire && rx_data == SYNC_BYTE) state_next = S_CH;
            S_CH:   if (rx_fire) state_next = S_D2;
            S_D2:   if (rx_fire) state_next = S_D1;
            S_D1:   if (rx_fire) state_next = S_D0;
            S_D0:   if (rx_fire) state_next = S_CK;
            S_CK:   if (rx_fire) state_next = S_RESP;
            S_RESP: if (tx_fire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // A stalled frame is dropped silently.
        if (timeout_hit) state_next = S_IDLE;
    end

    // ------------------------------------------------------------------
    // FSM: output / decode logic
    // ------------------------------------------------------------------
    always_comb begin
        tx_valid    = 1'b0;
        in_frame    = 1'b0;
        ck_fire     = 1'b0;
        ck_ok       = 1'b0;
        ch_ok       = 1'b0;
        ch_bcast    = 1'b0;
        commit_one  = 1'b0;
        commit_all  = 1'b0;
        timeout_hit = 1'b0;

        tx_valid = (state == S_RESP);
        in_frame = (state == S_CH) || (state == S_D2) || (state == S_D1) ||
                   (state == S_D0) || (state == S_CK);
        ck_fire  = (state == S_CK) && rx_fire;
        ck_ok    = (rx_data == (ch_q ^ d2_q ^ d1_q ^ d0_q));
        ch_ok    = ({24'd0, ch_q} < 32'(OUTPUTS));
`ifdef OFFSET_BROADCAST_EN
        ch_bcast = (ch_q == 8'hFF);
`else
        ch_bcast = 1'b0;
`endif
        commit_one  = ck_fire && ck_ok && ch_ok;
        commit_all  = ck_fire && ck_ok && ch_bcast;
        // An accepted byte on the same edge wins over the timeout.
        timeout_hit = in_frame && !rx_fire && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    end

    // ------------------------------------------------------------------
    // Datapath: frame capture, reply, reload, timeout, offsets bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q       <= 8'd0;
            d2_q       <= 8'd0;
            d1_q       <= 8'd0;
            d0_q       <= 8'd0;
            cnt_q      <= '0;
            tx_data_q  <= 8'd0;
            rx_ready_q <= 1'b0;
            reload_q   <= 1'b0;
            for (int i = 0; i < OUTPUTS; i++) begin
                off_q[i] <= OFFSET_W'(10 * i);
            end
        end else begin
            // Registered so it stays low while reset is held and rises on
            // the first edge after release.
            rx_ready_q <= (state_next != S_RESP);
            reload_q   <= !(commit_one || commit_all);

            if (rx_fire) begin
                case (state)
                    S_CH:    ch_q <= rx_data;
                    S_D2:    d2_q <= rx_data;
                    S_D1:    d1_q <= rx_data;
                    S_D0:    d0_q <= rx_data;
                    default: ;
                endcase
            end

            if (ck_fire) begin
                tx_data_q <= (commit_one || commit_all) ? ACK_BYTE : NAK_BYTE;
            end

            if (!in_frame || rx_fire || timeout_hit) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            for (int i = 0; i < OUTPUTS; i++) begin
                if (commit_all || (commit_one && ch_q == 8'(i))) begin
                    off_q[i] <= new_off;
                end
            end
        end
    end

    assign rx_ready = rx_ready_q;
    assign tx_data  = tx_data_q;
    assign reload   = reload_q;

    for (genvar g = 0; g < OUTPUTS; g++) begin : g_pack
        assign offsets[OFFSET_W*g +: OFFSET_W] = off_q[g];
    end

endmodule

// File: tb/tb_offset_cmd_loader.sv
// ---------------------------------------------------------------------------
// tb_offset_cmd_loader
//
// Self-checking bench for offset_cmd_loader. A small reference model keeps
// the expected offsets bank as a plain array and decides ACK/NAK for each
// frame from the checksum and channel-range rules; expected reply bytes go
// through an expected queue. The timeout is shortened so the timeout
// scenarios stay short.
// ---------------------------------------------------------------------------
module tb_offset_cmd_loader;

    localparam int         OUTPUTS  = 16;
    localparam int         OFFSET_W = 24;
    localparam int         TMO      = 200;
    localparam logic [7:0] SYNC     = 8'hAA;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    // ---------------- clock / reset ----------------
    logic                        clk = 1'b0;
    logic                        rst;
    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic                        rx_ready;
    logic [7:0]                  tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [OUTPUTS*OFFSET_W-1:0] offsets;
    logic                        reload;

    always #5 clk = ~clk;

    offset_cmd_loader #(
        .OUTPUTS(OUTPUTS),
        .OFFSET_W(OFFSET_W),
        .SYNC_BYTE(SYNC),
        .ACK_BYTE(ACK),
        .NAK_BYTE(NAK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .offsets(offsets),
        .reload(reload)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [OFFSET_W-1:0] model_off [OUTPUTS];
    logic [7:0]          exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < OUTPUTS; i++) model_off[i] = OFFSET_W'(10 * i);
    endfunction

    function automatic logic [OUTPUTS*OFFSET_W-1:0] model_vec();
        logic [OUTPUTS*OFFSET_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUTPUTS; i++) v[i*OFFSET_W +: OFFSET_W] = model_off[i];
        return v;
    endfunction

    // Applies one complete frame to the model and returns the reply byte.
    function automatic logic [7:0] model_apply(input logic [7:0] ch, d2, d1, d0, ck);
        logic [23:0] value;
        bit          good_ck;
        bit          bcast;
        value   = {d2, d1, d0};
        good_ck = (ck == (ch ^ d2 ^ d1 ^ d0));
        bcast   = 1'b0;
`ifdef OFFSET_BROADCAST_EN
        bcast   = (ch == 8'hFF);
`endif
        if (good_ck && int'(ch) < OUTPUTS) begin
            model_off[int'(ch)] = OFFSET_W'(value);
            return ACK;
        end
        if (good_ck && bcast) begin
            for (int i = 0; i < OUTPUTS; i++) model_off[i] = OFFSET_W'(value);
            return ACK;
        end
        return NAK;
    endfunction

    // ---------------- driver tasks (all start and end at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = (rx_ready === 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ch, d2, d1, d0, ck,
                              input int long_gap, output bit ok);
        logic [7:0] bytes [6];
        bit         b_ok;
        int         gap;
        bytes = '{SYNC, ch, d2, d1, d0, ck};
        ok    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            gap = (k == 4 && long_gap > 0) ? long_gap : int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            send_byte(bytes[k], b_ok);
            ok = ok & b_ok;
        end
    endtask

    // Observes the reply after the CK byte, holds tx_ready low for 'stall'
    // cycles, then accepts it. Optionally keeps a non-SYNC byte pending on rx.
    task automatic take_reply(input int stall, input bit hold_rx,
                              output bit seen, output logic [7:0] got,
                              output int lows, output bit stable,
                              output bit blocked, output bit released);
        lows    = 0;
        seen    = (tx_valid === 1'b1);
        got     = tx_data;
        blocked = (rx_ready === 1'b0);
        stable  = 1'b1;
        if (reload === 1'b0) lows++;
        if (hold_rx) begin
            rx_data  = 8'h55;
            rx_valid = 1'b1;
        end
        repeat (stall) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== got || rx_ready !== 1'b0) stable = 1'b0;
            if (reload === 1'b0) lows++;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        released = (tx_valid === 1'b0 && rx_ready === 1'b1);
        if (reload === 1'b0) lows++;
        if (hold_rx) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // One full frame with its reply, compared against the model.
    task automatic frame_scenario(input string name, input logic [7:0] ch, d2, d1, d0, ck,
                                  input int stall, input int long_gap, input bit hold_rx);
        bit         ok;
        bit         seen;
        bit         stable;
        bit         blocked;
        bit         released;
        logic [7:0] got;
        logic [7:0] want;
        int         lows;
        int         want_lows;
        exp_q.push_back(model_apply(ch, d2, d1, d0, ck));
        send_frame(ch, d2, d1, d0, ck, long_gap, ok);
        take_reply(stall, hold_rx, seen, got, lows, stable, blocked, released);
        want      = exp_q.pop_front();
        want_lows = (want == ACK) ? 1 : 0;

        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s rx_accept: rx_ready stayed %b, required 1", name, rx_ready);
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s tx_valid: got %b after CK, required 1", name, seen);
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s reply: got %02h, required %02h", name, got, want);
        end
        checks++;
        if (lows != want_lows) begin
            errors++;
            $display("FAIL %s reload_low_cycles: got %0d, required %0d", name, lows, want_lows);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL %s resp_stable: got %b, required 1", name, stable);
        end
        checks++;
        if (blocked !== 1'b1) begin
            errors++;
            $display("FAIL %s rx_ready_in_resp: got %b, required 0", name, rx_ready);
        end
        checks++;
        if (released !== 1'b1) begin
            errors++;
            $display("FAIL %s release: tx_valid=%b rx_ready=%b, required 0/1", name, tx_valid, rx_ready);
        end
        checks++;
        if (offsets !== model_vec()) begin
            errors++;
            $display("FAIL %s offsets: got %h, required %h", name, offsets, model_vec());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int early_tx;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (offsets !== model_vec()) begin
            errors++;
            $display("FAIL reset offsets: got %h, required %h", offsets, model_vec());
        end
        checks++;
        if (reload !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset ctrl: reload=%b rx_ready=%b tx_valid=%b, required 0/0/0",
                     reload, rx_ready, tx_valid);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset tx_data: got %02h, required 00", tx_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (reload !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_before_edge: reload=%b rx_ready=%b, required 0/0", reload, rx_ready);
        end
        @(negedge clk);
        checks++;
        if (reload !== 1'b1 || rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_first_edge: reload=%b rx_ready=%b tx_valid=%b, required 1/1/0",
                     reload, rx_ready, tx_valid);
        end
        // tx_ready high with nothing to send must not produce a reply.
        tx_ready = 1'b1;
        early_tx = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) early_tx++;
        end
        tx_ready = 1'b0;
        checks++;
        if (early_tx != 0 || offsets !== model_vec()) begin
            errors++;
            $display("FAIL idle_tx_ready: tx_valid cycles %0d, required 0", early_tx);
        end
    endtask

    task automatic test_ack();
        // Checksum of 03 12 34 56 is 0x73; 0x71 is a bad checksum.
        frame_scenario("ack_ch3", 8'h03, 8'h12, 8'h34, 8'h56, 8'h73, 0, 0, 1'b0);
        frame_scenario("ck71_ch3", 8'h03, 8'h12, 8'h34, 8'h56, 8'h71, 1, 0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        frame_scenario("bad_ck_ch2", 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 2, 0, 1'b0);
    endtask

    task automatic test_bad_channel();
        frame_scenario("bad_ch_10", 8'h10, 8'h00, 8'h00, 8'h05, 8'h15, 0, 0, 1'b0);
        frame_scenario("last_ch_0f", 8'h0F, 8'hAB, 8'hCD, 8'hEF, 8'h0F ^ 8'hAB ^ 8'hCD ^ 8'hEF,
                       0, 0, 1'b0);
    endtask

    task automatic test_broadcast();
        frame_scenario("bcast_ff", 8'hFF, 8'h00, 8'h00, 8'h07, 8'hF8, 1, 0, 1'b0);
    endtask

    task automatic test_timeout();
        bit ok1;
        bit ok2;
        int bad;
        send_byte(SYNC, ok1);
        send_byte(8'h01, ok2);
        bad = 0;
        repeat (TMO + 2) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || reload !== 1'b1) bad++;
        end
        checks++;
        if (!(ok1 && ok2) || bad != 0) begin
            errors++;
            $display("FAIL timeout_silent: accepted=%b bad cycles %0d, required 1 and 0", ok1 && ok2, bad);
        end
        frame_scenario("timeout_recover", 8'h01, 8'h00, 8'h00, 8'h09, 8'h08, 0, 0, 1'b0);
    endtask

    task automatic test_timeout_gap();
        // A gap just under the timeout between bytes must not abort the frame.
        frame_scenario("long_gap", 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h04 ^ 8'h0A ^ 8'h0B ^ 8'h0C,
                       0, TMO - 1, 1'b0);
    endtask

    task automatic test_backpressure();
        frame_scenario("stall100", 8'h05, 8'h00, 8'h12, 8'h34, 8'h05 ^ 8'h12 ^ 8'h34, 100, 0, 1'b1);
        frame_scenario("after_stall", 8'h06, 8'h65, 8'h43, 8'h21, 8'h06 ^ 8'h65 ^ 8'h43 ^ 8'h21,
                       0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] ch;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
        logic [7:0] ck;
        logic [7:0] junk;
        int         r;
        bit         ok;
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      ch = 8'hFF;
            else if (r == 1) ch = 8'($urandom_range(16, 254));
            else             ch = 8'($urandom_range(0, 15));
            d2 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            d0 = 8'($urandom_range(0, 255));
            ck = ch ^ d2 ^ d1 ^ d0;
            if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == SYNC) junk = 8'h00;
                send_byte(junk, ok);
                checks++;
                if (ok !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_junk accept: rx_ready %b, required 1", rx_ready);
                end
            end
            frame_scenario($sformatf("rand%0d", n), ch, d2, d1, d0, ck,
                           int'($urandom_range(0, 3)), 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit ok1;
        bit ok2;
        bit ok3;
        // Reset while the reply is pending.
        void'(model_apply(8'h07, 8'h01, 8'h02, 8'h03, 8'h07 ^ 8'h01 ^ 8'h02 ^ 8'h03));
        send_frame(8'h07, 8'h01, 8'h02, 8'h03, 8'h07 ^ 8'h01 ^ 8'h02 ^ 8'h03, 0, ok);
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (!ok || tx_valid !== 1'b0 || rx_ready !== 1'b0 || reload !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_resp: tx_valid=%b rx_ready=%b reload=%b tx_data=%02h, required 0/0/0/00",
                     tx_valid, rx_ready, reload, tx_data);
        end
        checks++;
        if (offsets !== model_vec()) begin
            errors++;
            $display("FAIL reset_in_resp offsets: got %h, required %h", offsets, model_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || reload !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_resp release: rx_ready=%b reload=%b, required 1/1", rx_ready, reload);
        end
        // Reset partway through a frame.
        send_byte(SYNC, ok1);
        send_byte(8'h07, ok2);
        send_byte(8'h11, ok3);
        rst = 1'b1;
        #1;
        checks++;
        if (!(ok1 && ok2 && ok3) || rx_ready !== 1'b0 || reload !== 1'b0 || offsets !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_frame: rx_ready=%b reload=%b offsets=%h, required 0/0/%h",
                     rx_ready, reload, offsets, model_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame_scenario("after_reset", 8'h07, 8'h22, 8'h33, 8'h44, 8'h07 ^ 8'h22 ^ 8'h33 ^ 8'h44,
                       0, 0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ack();
        test_bad_checksum();
        test_bad_channel();
        test_broadcast();
        test_timeout();
        test_timeout_gap();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time bound reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
